// File: rtl/ahbl_pkg.sv
// Shared definitions for the AHB-Lite address decoder: HTRANS encodings,
// default geometry and the default-slave state encoding.
package ahbl_pkg;

   // HTRANS encodings
   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   // Default decoder geometry: 26 slaves, one per 64 MiB region
   localparam int NS_DEF      = 26;
   localparam int RGN_LSB_DEF = 26;

   // Default slave states; ERR1 is the wait cycle, ERR2 the ready cycle
   typedef enum logic [1:0] {
      DS_IDLE = 2'b00,
      DS_ERR1 = 2'b01,
      DS_ERR2 = 2'b10
   } def_state_e;

   // Region index of an address: everything at and above bit lsb
   function automatic logic [31:0] region_of(input logic [31:0] addr, input int lsb);
      return addr >> lsb;
   endfunction

   // True for transfer types that carry data (NONSEQ or SEQ)
   function automatic logic is_active(input logic [1:0] trans);
      return (trans == HTRANS_NONSEQ) || (trans == HTRANS_SEQ);
   endfunction

endpackage

// File: rtl/ahbl_dec_chk.sv
// Property checker for the decoder outputs; instantiated alongside the decoder.
module ahbl_dec_chk #(
   parameter int NS = 26
) (
   input logic          hclk,
   input logic          hreset,
   input logic [NS-1:0] dsel,
   input logic          dsel_def,
   input logic          def_hreadyout,
   input logic          def_hresp
);

   // Exactly one data-phase target is selected at any time
   a_dsel_onehot: assert property (@(posedge hclk) disable iff (hreset)
      $onehot({dsel, dsel_def}));

   // A wait cycle from the default slave is always an error wait
   a_wait_is_err: assert property (@(posedge hclk) disable iff (hreset)
      !def_hreadyout |-> def_hresp);

   // The error wait cycle is always followed by the error ready cycle
   a_err_two_cycle: assert property (@(posedge hclk) disable iff (hreset)
      !def_hreadyout |=> (def_hreadyout && def_hresp));

endmodule

// File: rtl/ahbl_def_slv.sv
// Internal default slave: zero-wait OKAY for idle traffic to unmapped space,
// two-cycle ERROR response for accepted NONSEQ/SEQ to unmapped space.
module ahbl_def_slv
   import ahbl_pkg::*;
(
   input  logic       hclk,
   input  logic       hreset,
   input  logic       hready,
   input  logic [1:0] htrans,
   input  logic       unmapped,
   output logic       def_hreadyout,
   output logic       def_hresp
);

   def_state_e state_q;
   def_state_e state_d;
   logic       err_start_s;
   logic       hreadyout_d;
   logic       hreadyout_q;
   logic       hresp_d;
   logic       hresp_q;

   // Next-state logic; ERR1 always proceeds to ERR2 so an error is never cut short
   always_comb begin
      state_d     = DS_IDLE;
      err_start_s = hready & is_active(htrans) & unmapped;
      case (state_q)
         DS_IDLE: begin
            if (err_start_s) begin
               state_d = DS_ERR1;
            end else begin
               state_d = DS_IDLE;
            end
         end
         DS_ERR1: begin
            state_d = DS_ERR2;
         end
         DS_ERR2: begin
            if (err_start_s) begin
               state_d = DS_ERR1;
            end else begin
               state_d = DS_IDLE;
            end
         end
         default: begin
            state_d = DS_IDLE;
         end
      endcase
   end

   // Response outputs are decoded from the next state so they leave a flop
   always_comb begin
      hreadyout_d = 1'b1;
      hresp_d     = 1'b0;
      case (state_d)
         DS_IDLE: begin
            hreadyout_d = 1'b1;
            hresp_d     = 1'b0;
         end
         DS_ERR1: begin
            hreadyout_d = 1'b0;
            hresp_d     = 1'b1;
         end
         DS_ERR2: begin
            hreadyout_d = 1'b1;
            hresp_d     = 1'b1;
         end
         default: begin
            hreadyout_d = 1'b1;
            hresp_d     = 1'b0;
         end
      endcase
   end

   // State and response registers; reset aborts any response in progress
   always_ff @(posedge hclk) begin
      if (hreset) begin
         state_q     <= DS_IDLE;
         hreadyout_q <= 1'b1;
         hresp_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         hreadyout_q <= hreadyout_d;
         hresp_q     <= hresp_d;
      end
   end

   assign def_hreadyout = hreadyout_q;
   assign def_hresp     = hresp_q;

endmodule

// File: rtl/ahbl_dec.sv
// AHB-Lite address decoder: combinational address-phase slave select,
// registered data-phase select, and the internal default slave.
module ahbl_dec
   import ahbl_pkg::*;
#(
   parameter int NS      = NS_DEF,
   parameter int RGN_LSB = RGN_LSB_DEF
) (
   input  logic          hclk,
   input  logic          hreset,
   input  logic [31:0]   haddr,
   input  logic [1:0]    htrans,
   input  logic          hready,
   output logic [NS-1:0] hsel,
   output logic [NS-1:0] dsel,
   output logic          dsel_def,
   output logic          def_hreadyout,
   output logic          def_hresp
);

   logic [31:0]   rgn_s;
   logic          unmapped_s;
   logic [NS-1:0] hsel_s;
   logic [NS-1:0] dsel_d;
   logic [NS-1:0] dsel_q;
   logic          dsel_def_d;
   logic          dsel_def_q;

   // Region decode; depends on haddr only, never on hready or htrans
   always_comb begin
      rgn_s      = region_of(haddr, RGN_LSB);
      unmapped_s = (rgn_s >= 32'(NS));
      hsel_s     = {NS{1'b0}};
      for (int i = 0; i < NS; i++) begin
         if (rgn_s == 32'(i)) begin
            hsel_s[i] = 1'b1;
         end else begin
            hsel_s[i] = 1'b0;
         end
      end
   end

   // Data-phase select advances only when the bus accepts the address phase
   always_comb begin
      dsel_d     = dsel_q;
      dsel_def_d = dsel_def_q;
      if (hready) begin
         dsel_d     = hsel_s;
         dsel_def_d = unmapped_s;
      end else begin
         dsel_d     = dsel_q;
         dsel_def_d = dsel_def_q;
      end
   end

   // Data-phase select registers; reset parks the data phase on the default slave
   always_ff @(posedge hclk) begin
      if (hreset) begin
         dsel_q     <= {NS{1'b0}};
         dsel_def_q <= 1'b1;
      end else begin
         dsel_q     <= dsel_d;
         dsel_def_q <= dsel_def_d;
      end
   end

   assign hsel     = hsel_s;
   assign dsel     = dsel_q;
   assign dsel_def = dsel_def_q;

   ahbl_def_slv u_def_slv (
      .hclk          (hclk),
      .hreset        (hreset),
      .hready        (hready),
      .htrans        (htrans),
      .unmapped      (unmapped_s),
      .def_hreadyout (def_hreadyout),
      .def_hresp     (def_hresp)
   );

endmodule
